// File: rtl/demux2_stream_pkg.sv
// Shared select encoding for the 1-to-2 stream demultiplexer.
package demux2_stream_pkg;
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;
endpackage

// File: rtl/demux2_slot.sv
// One output channel: a single-entry data register, its valid flag and an accept counter.
module demux2_slot #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_q,
    output logic             valid_q,
    output logic             free,
    output logic [CNT_W-1:0] cnt
);
    logic [WIDTH-1:0] data_d;
    logic             valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A full slot that drains this cycle can take a new word in the same cycle.
    assign free = !valid_q || out_ready;
    assign cnt  = cnt_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (load) begin
            data_d  = data;
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demux: each word goes to the slot chosen by s, strictly in order.
module demux2_stream
    import demux2_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y1,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    logic free0, free1;
    logic accept, load0, load1;

    // Only the selected slot gates readiness, so a stalled head word blocks both channels.
    assign in_ready = rst_n && ((s == CH1) ? free1 : free0);
    assign accept   = in_valid && in_ready;
    assign load0    = accept && (s == CH0);
    assign load1    = accept && (s == CH1);

    demux2_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load0),
        .data      (d),
        .out_ready (y0_ready),
        .data_q    (y0),
        .valid_q   (y0_valid),
        .free      (free0),
        .cnt       (cnt0)
    );

    demux2_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load1),
        .data      (d),
        .out_ready (y1_ready),
        .data_q    (y1),
        .valid_q   (y1_valid),
        .free      (free1),
        .cnt       (cnt1)
    );
endmodule
